// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit carry-look-ahead slice with group propagate/generate.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products of ci and the bit terms; nothing chains.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;
  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_look_ahead_adder.sv
// rtl/carry_look_ahead_adder.sv - registered N-bit two-level carry-look-ahead adder.
module carry_look_ahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GROUP = 4;
  localparam int NG    = WIDTH / GROUP;

  generate
    if ((WIDTH < GROUP) || ((WIDTH % GROUP) != 0)) begin : g_bad_width
      $error("carry_look_ahead_adder: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  logic [NG-1:0]  grp_pg;
  logic [NG-1:0]  grp_gg;
  logic [NG:0]    grp_c;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;
  logic             valid_q;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .a  (a[gi*GROUP +: GROUP]),
      .b  (b[gi*GROUP +: GROUP]),
      .ci (grp_c[gi]),
      .s  (sum_d[gi*GROUP +: GROUP]),
      .pg (grp_pg[gi]),
      .gg (grp_gg[gi])
    );
  end

  // Second look-ahead level: each group carry-in is an independent product-sum
  // over the lower groups' GG/PG and cin, so group carries never ripple.
  always_comb begin
    logic term;
    logic acc;
    grp_c    = '0;
    grp_c[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      term = cin;
      for (int k = 0; k < j; k++) term = term & grp_pg[k];
      acc = term;
      for (int k = 0; k < j; k++) begin
        term = grp_gg[k];
        for (int m = k + 1; m < j; m++) term = term & grp_pg[m];
        acc = acc | term;
      end
      grp_c[j] = acc;
    end
  end

  assign cout_d = grp_c[NG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// tb/tb_carry_look_ahead_adder.sv - randomized and directed checks against an arithmetic model.
module tb_carry_look_ahead_adder;

  logic        clk;
  logic        rst_n;

  logic        v4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  logic        ov4;
  logic [3:0]  sum4;
  logic        cout4;

  logic        v16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic        ov16;
  logic [15:0] sum16;
  logic        cout16;

  int n_vec;
  int n_err;

  // Model state: the last accepted result per instance
  logic [3:0]  m_sum4;
  logic        m_cout4;
  logic [15:0] m_sum16;
  logic        m_cout16;

  carry_look_ahead_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (ov4),
    .sum       (sum4),
    .cout      (cout4)
  );

  carry_look_ahead_adder #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .out_valid (ov16),
    .sum       (sum16),
    .cout      (cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                       input logic tv, input string tag);
    int tot;
    a4 = ta; b4 = tb_; cin4 = tc; v4 = tv;
    if (tv) begin
      tot     = int'(ta) + int'(tb_) + int'(tc);
      m_sum4  = tot[3:0];
      m_cout4 = tot[4];
    end
    @(posedge clk);
    #1;
    check({tag, ".sum"},   32'(sum4),  32'(m_sum4));
    check({tag, ".cout"},  32'(cout4), 32'(m_cout4));
    check({tag, ".valid"}, 32'(ov4),   32'(tv));
  endtask

  task automatic step16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic tv, input string tag);
    int tot;
    a16 = ta; b16 = tb_; cin16 = tc; v16 = tv;
    if (tv) begin
      tot      = int'(ta) + int'(tb_) + int'(tc);
      m_sum16  = tot[15:0];
      m_cout16 = tot[16];
    end
    @(posedge clk);
    #1;
    check({tag, ".sum"},   32'(sum16),  32'(m_sum16));
    check({tag, ".cout"},  32'(cout16), 32'(m_cout16));
    check({tag, ".valid"}, 32'(ov16),   32'(tv));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_sum4 = '0; m_cout4 = 1'b0; m_sum16 = '0; m_cout16 = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst.sum4",   32'(sum4),   32'd0);
    check("rst.cout4",  32'(cout4),  32'd0);
    check("rst.valid4", 32'(ov4),    32'd0);
    check("rst.sum16",  32'(sum16),  32'd0);
    check("rst.valid16", 32'(ov16),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner vectors
    step4(4'd0,  4'd0,  1'b0, 1'b1, "zero");
    step4(4'd2,  4'd6,  1'b1, 1'b1, "2+6+1");
    step4(4'd15, 4'd13, 1'b0, 1'b1, "wrap");
    step4(4'd10, 4'd5,  1'b0, 1'b1, "prop");
    step4(4'd3,  4'd12, 1'b1, 1'b1, "cin_chain");
    step4(4'd15, 4'd15, 1'b1, 1'b1, "max");

    step4(4'd1, 4'd1, 1'b0, 1'b1, "hold_a");
    step4(4'd7, 4'd7, 1'b0, 1'b0, "hold_b");
    check("hold.sum_is_2", 32'(sum4), 32'd2);

    // Reset in the middle of a stream discards the in-flight result
    step4(4'd15, 4'd15, 1'b1, 1'b1, "pre_rst");
    rst_n = 1'b0;
    #1;
    check("midrst.sum",   32'(sum4),  32'd0);
    check("midrst.cout",  32'(cout4), 32'd0);
    check("midrst.valid", 32'(ov4),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.sum_still0",   32'(sum4), 32'd0);
    check("rel.valid_still0", 32'(ov4),  32'd0);
    @(posedge clk);
    #1;
    check("rel.sum",   32'(sum4),  32'd15);
    check("rel.cout",  32'(cout4), 32'd1);
    check("rel.valid", 32'(ov4),   32'd1);
    m_sum4 = 4'd15; m_cout4 = 1'b1;

    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      step4(iv[3:0], iv[7:4], iv[8], 1'b1, "exh");
    end
    step4(4'd0, 4'd0, 1'b0, 1'b0, "idle4");

    step16(16'hFFFF, 16'h0000, 1'b1, 1'b1, "w_ffff_cin");
    step16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "w_max");
    step16(16'h0FFF, 16'h0001, 1'b0, 1'b1, "w_grp_carry");
    step16(16'h8000, 16'h8000, 1'b0, 1'b1, "w_top");

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] r;
      logic [15:0] ra;
      logic [15:0] rb;
      r  = $urandom;
      ra = r[15:0];
      rb = r[31:16];
      if ((i % 7) == 0) ra = 16'hFFFF ^ rb;
      step16(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), "rnd16");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
